// File: rtl/hr_pkg.sv
// hr_pkg -- shared definitions for the heart-rate LUT display controller.
//
// Contents:
//   hr_state_t            sequencer state encoding
//   HR_*_DEF              default LUT base, display IO addresses and highest index
//   HR_LUT_ENTRY_BYTES    bytes per LUT entry (low BCD byte, then high BCD byte)
//   hr_entry_addr()       8-bit (modulo 256) address of one byte of a LUT entry
package hr_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      RD_LO = 3'd1,
      RD_HI = 3'd2,
      WR_LO = 3'd3,
      WR_HI = 3'd4,
      DONE  = 3'd5
   } hr_state_t;

   localparam logic [7:0] HR_LUT_BASE_DEF     = 8'd0;
   localparam logic [7:0] HR_DISP_LO_ADDR_DEF = 8'd252;
   localparam logic [7:0] HR_DISP_HI_ADDR_DEF = 8'd253;
   localparam int         HR_MAX_INDEX_DEF    = 29;
   localparam int         HR_LUT_ENTRY_BYTES  = 2;

   // Byte address of entry idx; hi_sel picks the second byte of the entry.
   // All terms are 8 bits wide so the sum wraps modulo 256.
   function automatic logic [7:0] hr_entry_addr(input logic [7:0] base,
                                                input logic [4:0] idx,
                                                input logic       hi_sel);
      logic [7:0] offset;
      offset = 8'(idx) * 8'(HR_LUT_ENTRY_BYTES);
      return base + offset + {7'd0, hi_sel};
   endfunction

endpackage

// File: rtl/hr_port_mux.sv
// hr_port_mux -- arbitration of the single shared memory port.
//
// Ports:
//   seq_sel                     1 = sequencer owns the port, 0 = CPU owns it
//   cpu_req/addr/data/mw        CPU side request
//   cpu_q, cpu_stall            CPU side response
//   seq_addr/data/mw            sequencer side drive
//   mem_addr/data/mw, mem_q     shared memory port
//
// An undriven port (CPU owner without a request) parks at address/data 0
// with the write enable low.
module hr_port_mux (
   input  logic       seq_sel,
   input  logic       cpu_req,
   input  logic [7:0] cpu_addr,
   input  logic [7:0] cpu_data,
   input  logic       cpu_mw,
   output logic [7:0] cpu_q,
   output logic       cpu_stall,
   input  logic [7:0] seq_addr,
   input  logic [7:0] seq_data,
   input  logic       seq_mw,
   output logic [7:0] mem_addr,
   output logic [7:0] mem_data,
   output logic       mem_mw,
   input  logic [7:0] mem_q
);

   always_comb begin
      mem_addr  = 8'd0;
      mem_data  = 8'd0;
      mem_mw    = 1'b0;
      cpu_q     = 8'd0;
      cpu_stall = 1'b0;
      if (seq_sel) begin
         mem_addr  = seq_addr;
         mem_data  = seq_data;
         mem_mw    = seq_mw;
         cpu_stall = cpu_req;
      end else begin
         cpu_q = mem_q;
         if (cpu_req) begin
            mem_addr = cpu_addr;
            mem_data = cpu_data;
            mem_mw   = cpu_mw;
         end
      end
   end

endmodule

// File: rtl/hr_lut_ctrl.sv
// hr_lut_ctrl -- reads a 2-byte BCD entry from a lookup table in shared
// memory and writes it to the two display IO addresses.
//
// Ports:
//   CLK, RESET          clock; synchronous active-high reset
//   cpu_req/addr/data/mw, cpu_q, cpu_stall   CPU access to the shared port
//   hr_start, hr_index  start a display of LUT entry hr_index
//   hr_busy             sequencer owns the memory port
//   hr_done             one-cycle pulse after both display bytes are written
//   hr_err              one-cycle pulse when an index is rejected
//   mem_addr/data/mw, mem_q   shared memory port (mem_q combinational)
//
// Build option: define HR_LUT_CLAMP_EN to clamp out-of-range indices to
// MAX_INDEX instead of rejecting them (hr_err is then constant 0).
module hr_lut_ctrl
   import hr_pkg::*;
#(
   parameter logic [7:0] LUT_BASE     = HR_LUT_BASE_DEF,
   parameter int         MAX_INDEX    = HR_MAX_INDEX_DEF,
   parameter logic [7:0] DISP_LO_ADDR = HR_DISP_LO_ADDR_DEF,
   parameter logic [7:0] DISP_HI_ADDR = HR_DISP_HI_ADDR_DEF
) (
   input  logic       CLK,
   input  logic       RESET,
   input  logic       cpu_req,
   input  logic [7:0] cpu_addr,
   input  logic [7:0] cpu_data,
   input  logic       cpu_mw,
   output logic [7:0] cpu_q,
   output logic       cpu_stall,
   input  logic       hr_start,
   input  logic [4:0] hr_index,
   output logic       hr_busy,
   output logic       hr_done,
   output logic       hr_err,
   output logic [7:0] mem_addr,
   output logic [7:0] mem_data,
   output logic       mem_mw,
   input  logic [7:0] mem_q
);

   hr_state_t  state_q, state_d;
   logic [4:0] idx_q;
   logic [7:0] lo_byte_q;
   logic [7:0] hi_byte_q;

   logic       idle;
   logic       idx_over;
   logic       start_acc;
   logic [4:0] idx_load;

   logic [7:0] seq_addr;
   logic [7:0] seq_data;
   logic       seq_mw;

   assign idle     = (state_q == IDLE);
   assign idx_over = (int'(hr_index) > MAX_INDEX);

`ifdef HR_LUT_CLAMP_EN
   // Out-of-range requests run against the last valid entry.
   assign start_acc = idle & hr_start;
   assign idx_load  = idx_over ? 5'(MAX_INDEX) : hr_index;
   assign hr_err    = 1'b0;
`else
   logic err_q;

   // A rejected request leaves the FSM idle and reports one cycle later.
   assign start_acc = idle & hr_start & ~idx_over;
   assign idx_load  = hr_index;
   assign hr_err    = err_q;

   always_ff @(posedge CLK) begin
      if (RESET) begin
         err_q <= 1'b0;
      end else begin
         err_q <= idle & hr_start & idx_over;
      end
   end
`endif

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q   <= IDLE;
         idx_q     <= 5'd0;
         lo_byte_q <= 8'd0;
         hi_byte_q <= 8'd0;
      end else begin
         state_q <= state_d;
         // The index is frozen at start; later hr_index changes are ignored.
         if (start_acc) begin
            idx_q <= idx_load;
         end
         if (state_q == RD_LO) begin
            lo_byte_q <= mem_q;
         end
         if (state_q == RD_HI) begin
            hi_byte_q <= mem_q;
         end
      end
   end

   always_comb begin
      state_d  = state_q;
      seq_addr = 8'd0;
      seq_data = 8'd0;
      seq_mw   = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (start_acc) begin
               state_d = RD_LO;
            end
         end
         RD_LO: begin
            seq_addr = hr_entry_addr(LUT_BASE, idx_q, 1'b0);
            state_d  = RD_HI;
         end
         RD_HI: begin
            seq_addr = hr_entry_addr(LUT_BASE, idx_q, 1'b1);
            state_d  = WR_LO;
         end
         WR_LO: begin
            seq_addr = DISP_LO_ADDR;
            seq_data = lo_byte_q;
            seq_mw   = 1'b1;
            state_d  = WR_HI;
         end
         WR_HI: begin
            seq_addr = DISP_HI_ADDR;
            seq_data = hi_byte_q;
            seq_mw   = 1'b1;
            state_d  = DONE;
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // The CPU keeps the port in IDLE (including the start cycle) and DONE.
   assign hr_busy = (state_q == RD_LO) || (state_q == RD_HI) ||
                    (state_q == WR_LO) || (state_q == WR_HI);
   assign hr_done = (state_q == DONE);

   hr_port_mux u_port_mux (
      .seq_sel   (hr_busy),
      .cpu_req   (cpu_req),
      .cpu_addr  (cpu_addr),
      .cpu_data  (cpu_data),
      .cpu_mw    (cpu_mw),
      .cpu_q     (cpu_q),
      .cpu_stall (cpu_stall),
      .seq_addr  (seq_addr),
      .seq_data  (seq_data),
      .seq_mw    (seq_mw),
      .mem_addr  (mem_addr),
      .mem_data  (mem_data),
      .mem_mw    (mem_mw),
      .mem_q     (mem_q)
   );

endmodule

// File: tb/tb_hr_lut_ctrl.sv
// tb_hr_lut_ctrl -- self-checking bench for hr_lut_ctrl with a byte-wide
// memory model, an activity log sampled mid-cycle and a reference model
// of the expected display transfer.
module tb_hr_lut_ctrl;

   logic       CLK = 1'b0;
   logic       RESET;
   logic       cpu_req;
   logic [7:0] cpu_addr;
   logic [7:0] cpu_data;
   logic       cpu_mw;
   logic [7:0] cpu_q;
   logic       cpu_stall;
   logic       hr_start;
   logic [4:0] hr_index;
   logic       hr_busy;
   logic       hr_done;
   logic       hr_err;
   logic [7:0] mem_addr;
   logic [7:0] mem_data;
   logic       mem_mw;
   logic [7:0] mem_q;

   hr_lut_ctrl dut (
      .CLK       (CLK),
      .RESET     (RESET),
      .cpu_req   (cpu_req),
      .cpu_addr  (cpu_addr),
      .cpu_data  (cpu_data),
      .cpu_mw    (cpu_mw),
      .cpu_q     (cpu_q),
      .cpu_stall (cpu_stall),
      .hr_start  (hr_start),
      .hr_index  (hr_index),
      .hr_busy   (hr_busy),
      .hr_done   (hr_done),
      .hr_err    (hr_err),
      .mem_addr  (mem_addr),
      .mem_data  (mem_data),
      .mem_mw    (mem_mw),
      .mem_q     (mem_q)
   );

   always #5 CLK = ~CLK;

   int cyc = 0;
   always @(posedge CLK) cyc <= cyc + 1;

   // Memory model: combinational read, write on the clock edge.
   logic [7:0] mem [256];
   logic [7:0] lut_ref [64];
   logic       ld_en = 1'b0;
   logic [7:0] ld_addr = 8'd0;
   logic [7:0] ld_data = 8'd0;

   assign mem_q = mem[mem_addr];

   always @(posedge CLK) begin
      if (ld_en) mem[ld_addr] <= ld_data;
      else if (mem_mw) mem[mem_addr] <= mem_data;
   end

   // Activity log, sampled on the falling edge.
   typedef struct {
      int         cyc;
      logic [7:0] addr;
      logic [7:0] data;
   } acc_t;

   acc_t wr_log[$];
   acc_t rd_log[$];
   int   done_log[$];
   int   err_log[$];
   int   stall_log[$];
   int   busy_log[$];
   int   cpuq_bad = 0;

   always @(negedge CLK) begin
      acc_t a;
      a.cyc  = cyc;
      a.addr = mem_addr;
      a.data = mem_data;
      if (mem_mw) wr_log.push_back(a);
      if (hr_busy && !mem_mw) rd_log.push_back(a);
      if (hr_done) done_log.push_back(cyc);
      if (hr_err) err_log.push_back(cyc);
      if (cpu_stall) stall_log.push_back(cyc);
      if (hr_busy) busy_log.push_back(cyc);
      if (hr_busy && cpu_q !== 8'd0) cpuq_bad = cpuq_bad + 1;
   end

   int vectors = 0;
   int miscompares = 0;

   // Reference model: entry actually displayed for a requested index.
   function automatic int eff_idx(input int i);
`ifdef HR_LUT_CLAMP_EN
      return (i > 29) ? 29 : i;
`else
      return i;
`endif
   endfunction

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic clear_logs();
      wr_log.delete();
      rd_log.delete();
      done_log.delete();
      err_log.delete();
      stall_log.delete();
      busy_log.delete();
      cpuq_bad = 0;
   endtask

   // Pulse hr_start for one cycle in cycle n and let the sequence finish.
   task automatic run_one(input logic [4:0] idx, output int n);
      clear_logs();
      hr_index = idx;
      hr_start = 1'b1;
      n = cyc;
      tick();
      hr_start = 1'b0;
      repeat (8) tick();
   endtask

   task automatic test_reset();
      RESET    = 1'b1;
      cpu_req  = 1'b1;
      cpu_mw   = 1'b0;
      cpu_addr = 8'd77;
      tick();
      vectors++;
      if (hr_busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b exp 0", hr_busy); end
      vectors++;
      if (hr_done !== 1'b0) begin miscompares++; $display("FAIL reset_done got %b exp 0", hr_done); end
      vectors++;
      if (hr_err !== 1'b0) begin miscompares++; $display("FAIL reset_err got %b exp 0", hr_err); end
      vectors++;
      if (cpu_stall !== 1'b0) begin miscompares++; $display("FAIL reset_stall got %b exp 0", cpu_stall); end
      vectors++;
      if (mem_mw !== 1'b0) begin miscompares++; $display("FAIL reset_mw got %b exp 0", mem_mw); end
      vectors++;
      if (mem_addr !== 8'd77) begin miscompares++; $display("FAIL reset_cpu_addr got %0d exp 77", mem_addr); end
      cpu_req = 1'b0;
      tick();
      vectors++;
      if (mem_addr !== 8'd0 || mem_data !== 8'd0) begin
         miscompares++;
         $display("FAIL idle_park got addr %0d data %0d exp 0 0", mem_addr, mem_data);
      end
      RESET = 1'b0;
      tick();
   endtask

   task automatic test_basic();
      int n;
      run_one(5'd10, n);
      vectors++;
      if (rd_log.size() != 2) begin
         miscompares++; $display("FAIL basic_rd_count got %0d exp 2", rd_log.size());
      end else begin
         vectors++;
         if (rd_log[0].cyc != n + 1 || rd_log[0].addr !== 8'd20 || rd_log[1].cyc != n + 2 || rd_log[1].addr !== 8'd21) begin
            miscompares++;
            $display("FAIL basic_rd got %0d@%0d %0d@%0d exp 20@%0d 21@%0d", rd_log[0].addr, rd_log[0].cyc, rd_log[1].addr, rd_log[1].cyc, n + 1, n + 2);
         end
      end
      vectors++;
      if (wr_log.size() != 2) begin
         miscompares++; $display("FAIL basic_wr_count got %0d exp 2", wr_log.size());
      end else begin
         vectors++;
         if (wr_log[0].cyc != n + 3 || wr_log[0].addr !== 8'd252 || wr_log[0].data !== 8'h89) begin
            miscompares++;
            $display("FAIL basic_wr_lo got %0d<=%h@%0d exp 252<=89@%0d", wr_log[0].addr, wr_log[0].data, wr_log[0].cyc, n + 3);
         end
         vectors++;
         if (wr_log[1].cyc != n + 4 || wr_log[1].addr !== 8'd253 || wr_log[1].data !== 8'h00) begin
            miscompares++;
            $display("FAIL basic_wr_hi got %0d<=%h@%0d exp 253<=00@%0d", wr_log[1].addr, wr_log[1].data, wr_log[1].cyc, n + 4);
         end
      end
      vectors++;
      if (done_log.size() != 1 || done_log[0] != n + 5) begin
         miscompares++;
         $display("FAIL basic_done got %0d pulses first@%0d exp 1@%0d", done_log.size(), (done_log.size() > 0) ? done_log[0] : -1, n + 5);
      end
      vectors++;
      if (busy_log.size() != 4 || busy_log[0] != n + 1 || busy_log[3] != n + 4) begin
         miscompares++;
         $display("FAIL basic_busy got %0d cycles exp 4 from %0d", busy_log.size(), n + 1);
      end
      vectors++;
      if (err_log.size() != 0) begin miscompares++; $display("FAIL basic_err got %0d pulses exp 0", err_log.size()); end
   endtask

   task automatic test_random();
      for (int k = 0; k < 8; k++) begin
         int n;
         int e;
         int req;
`ifdef HR_LUT_CLAMP_EN
         req = int'($urandom_range(0, 31));
`else
         req = int'($urandom_range(0, 29));
`endif
         e = eff_idx(req);
         run_one(5'(req), n);
         vectors++;
         if (rd_log.size() != 2 || rd_log[0].addr !== 8'(2 * e) || rd_log[1].addr !== 8'(2 * e + 1)) begin
            miscompares++;
            $display("FAIL rand_rd idx %0d got %0d reads exp addrs %0d,%0d", req, rd_log.size(), 2 * e, 2 * e + 1);
         end
         vectors++;
         if (wr_log.size() != 2 || wr_log[0].addr !== 8'd252 || wr_log[0].data !== lut_ref[2 * e] ||
             wr_log[1].addr !== 8'd253 || wr_log[1].data !== lut_ref[2 * e + 1]) begin
            miscompares++;
            $display("FAIL rand_wr idx %0d got %0d writes exp 252<=%h 253<=%h", req, wr_log.size(), lut_ref[2 * e], lut_ref[2 * e + 1]);
         end
         vectors++;
         if (done_log.size() != 1 || done_log[0] != n + 5) begin
            miscompares++;
            $display("FAIL rand_done idx %0d got %0d pulses exp 1@%0d", req, done_log.size(), n + 5);
         end
      end
   endtask

   task automatic test_stall();
      int n;
      int early;
      int bad;
      clear_logs();
      cpu_req  = 1'b1;
      cpu_mw   = 1'b1;
      cpu_addr = 8'd200;
      cpu_data = 8'hA5;
      hr_index = 5'd7;
      hr_start = 1'b1;
      n = cyc;
      tick();
      hr_start = 1'b0;
      repeat (7) tick();
      cpu_req = 1'b0;
      cpu_mw  = 1'b0;
      tick();
      vectors++;
      if (stall_log.size() != 4 || stall_log[0] != n + 1 || stall_log[3] != n + 4) begin
         miscompares++;
         $display("FAIL stall_window got %0d cycles first@%0d exp 4 from %0d", stall_log.size(), (stall_log.size() > 0) ? stall_log[0] : -1, n + 1);
      end
      early = 0;
      bad = 0;
      foreach (wr_log[i]) begin
         if (wr_log[i].addr == 8'd200 && wr_log[i].cyc == n) early++;
         if (wr_log[i].addr == 8'd200 && wr_log[i].cyc >= n + 1 && wr_log[i].cyc <= n + 4) bad++;
      end
      vectors++;
      if (bad != 0) begin miscompares++; $display("FAIL stall_cpu_write got %0d writes during busy exp 0", bad); end
      vectors++;
      if (early != 1) begin miscompares++; $display("FAIL start_cycle_cpu_write got %0d exp 1", early); end
      vectors++;
      if (cpuq_bad != 0) begin miscompares++; $display("FAIL stall_cpu_q got %0d nonzero cycles exp 0", cpuq_bad); end
      vectors++;
      if (mem[253] !== lut_ref[15] || mem[252] !== lut_ref[14]) begin
         miscompares++;
         $display("FAIL stall_disp got %h %h exp %h %h", mem[252], mem[253], lut_ref[14], lut_ref[15]);
      end
   endtask

   task automatic test_out_of_range();
      int n;
      run_one(5'd31, n);
`ifdef HR_LUT_CLAMP_EN
      vectors++;
      if (wr_log.size() != 2 || wr_log[0].data !== 8'h59 || wr_log[1].data !== 8'h02) begin
         miscompares++; $display("FAIL clamp_wr got %0d writes exp 59 then 02", wr_log.size());
      end
      vectors++;
      if (err_log.size() != 0) begin miscompares++; $display("FAIL clamp_err got %0d pulses exp 0", err_log.size()); end
      vectors++;
      if (done_log.size() != 1 || done_log[0] != n + 5) begin
         miscompares++; $display("FAIL clamp_done got %0d pulses exp 1@%0d", done_log.size(), n + 5);
      end
`else
      vectors++;
      if (err_log.size() != 1 || err_log[0] != n + 1) begin
         miscompares++;
         $display("FAIL range_err got %0d pulses first@%0d exp 1@%0d", err_log.size(), (err_log.size() > 0) ? err_log[0] : -1, n + 1);
      end
      vectors++;
      if (wr_log.size() != 0 || rd_log.size() != 0 || busy_log.size() != 0) begin
         miscompares++;
         $display("FAIL range_activity got wr %0d rd %0d busy %0d exp 0 0 0", wr_log.size(), rd_log.size(), busy_log.size());
      end
      vectors++;
      if (done_log.size() != 0) begin miscompares++; $display("FAIL range_done got %0d pulses exp 0", done_log.size()); end
`endif
   endtask

   task automatic test_back_to_back();
      int n;
      clear_logs();
      hr_index = 5'd10;
      hr_start = 1'b1;
      n = cyc;
      tick();
      hr_start = 1'b0;
      hr_index = 5'd29;
      tick();
      hr_start = 1'b1;
      tick();
      hr_start = 1'b0;
      repeat (10) tick();
      vectors++;
      if (done_log.size() != 1 || done_log[0] != n + 5) begin
         miscompares++; $display("FAIL b2b_done got %0d pulses exp 1@%0d", done_log.size(), n + 5);
      end
      vectors++;
      if (wr_log.size() != 2 || wr_log[0].data !== 8'h89 || wr_log[1].data !== 8'h00) begin
         miscompares++; $display("FAIL b2b_wr got %0d writes exp 89 then 00", wr_log.size());
      end
      vectors++;
      if (err_log.size() != 0) begin miscompares++; $display("FAIL b2b_err got %0d pulses exp 0", err_log.size()); end
   endtask

   task automatic test_reset_mid();
      int n;
      int hi_writes;
      clear_logs();
      hr_index = 5'd29;
      hr_start = 1'b1;
      tick();
      hr_start = 1'b0;
      tick();
      tick();
      RESET = 1'b1;
      tick();
      RESET = 1'b0;
      repeat (6) tick();
      hi_writes = 0;
      foreach (wr_log[i]) if (wr_log[i].addr == 8'd253) hi_writes++;
      vectors++;
      if (hi_writes != 0) begin miscompares++; $display("FAIL abort_wr_hi got %0d writes exp 0", hi_writes); end
      vectors++;
      if (done_log.size() != 0) begin miscompares++; $display("FAIL abort_done got %0d pulses exp 0", done_log.size()); end
      run_one(5'd10, n);
      vectors++;
      if (done_log.size() != 1 || done_log[0] != n + 5) begin
         miscompares++; $display("FAIL after_abort_done got %0d pulses exp 1@%0d", done_log.size(), n + 5);
      end
      vectors++;
      if (wr_log.size() != 2 || wr_log[0].data !== 8'h89 || wr_log[1].data !== 8'h00) begin
         miscompares++; $display("FAIL after_abort_wr got %0d writes exp 89 then 00", wr_log.size());
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      RESET    = 1'b1;
      cpu_req  = 1'b0;
      cpu_addr = 8'd0;
      cpu_data = 8'd0;
      cpu_mw   = 1'b0;
      hr_start = 1'b0;
      hr_index = 5'd0;
      for (int i = 0; i < 64; i++) lut_ref[i] = 8'($urandom_range(0, 255));
      lut_ref[20] = 8'h89;
      lut_ref[21] = 8'h00;
      lut_ref[58] = 8'h59;
      lut_ref[59] = 8'h02;
      tick();
      ld_en = 1'b1;
      for (int i = 0; i < 256; i++) begin
         ld_addr = 8'(i);
         ld_data = (i < 64) ? lut_ref[i] : 8'($urandom_range(0, 255));
         tick();
      end
      ld_en = 1'b0;

      test_reset();
      test_basic();
      test_random();
      test_stall();
      test_out_of_range();
      test_back_to_back();
      test_reset_mid();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
